// File: rtl/axi_rd_responder_pkg.sv
// Shared definitions for the AXI4 read responder.
//   - bus widths used as parameter defaults
//   - AR size codes, R response codes, FSM state encoding
//   - size_mask(): low address bits that must be zero for a given beat size
package axi_rd_responder_pkg;

  localparam int AXI_ADDR_BUS  = 64;
  localparam int AXI_LEN_WIDTH = 8;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    m = 3'b000;
    case (size)
      SIZE_B:  m = 3'b000;
      SIZE_H:  m = 3'b001;
      SIZE_W:  m = 3'b011;
      SIZE_D:  m = 3'b111;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read-channel bundle (AR + R).
//   master : drives ar_valid/ar_addr/ar_len/ar_size and r_ready
//   slave  : drives ar_ready and r_valid/r_data/r_resp/r_last
interface axi_rd_responder_if #(
  parameter int ADDR_W = axi_rd_responder_pkg::AXI_ADDR_BUS,
  parameter int DATA_W = 64,
  parameter int LEN_W  = axi_rd_responder_pkg::AXI_LEN_WIDTH
);

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [LEN_W-1:0]  ar_len;
  logic [1:0]        ar_size;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, r_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last
  );

endinterface

// File: rtl/axi_rd_addr_chk.sv
// Per-beat address check for the read responder (purely combinational).
//   addr      : current beat byte address
//   size      : log2 bytes per beat
//   resp      : DECERR outside the decoded window, SLVERR if misaligned, else OKAY
//   word_addr : 8-byte aligned word address for the memory
module axi_rd_addr_chk
  import axi_rd_responder_pkg::*;
#(
  parameter int                ADDR_W    = AXI_ADDR_BUS,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 64'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_BYTES = 64'h0800_0000
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  output resp_t             resp,
  output logic [ADDR_W-1:0] word_addr
);

  logic in_win;
  logic misaligned;

  // Offset form avoids overflow when MEM_BASE+MEM_BYTES reaches the top of the space.
  assign in_win     = (addr >= MEM_BASE) && ((addr - MEM_BASE) < MEM_BYTES);
  assign misaligned = |(addr[2:0] & size_mask(size));
  assign word_addr  = {addr[ADDR_W-1:3], 3'b000};

  always_comb begin
    resp = RESP_OKAY;
    if (!in_win)         resp = RESP_DECERR;
    else if (misaligned) resp = RESP_SLVERR;
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder backed by a single-port synchronous memory.
//   clk, reset : clock (rising edge) and asynchronous active-high reset
//   bus        : AR/R channels (slave side)
//   mem_en     : memory read strobe, only for beats that pass the address check
//   mem_addr   : 8-byte aligned word address
//   mem_rdata  : memory word, valid the cycle after mem_en
// One burst at a time; each beat walks RD -> WAIT -> RESP.
module axi_rd_responder
  import axi_rd_responder_pkg::*;
#(
  parameter int                ADDR_W    = AXI_ADDR_BUS,
  parameter int                DATA_W    = 64,
  parameter int                LEN_W     = AXI_LEN_WIDTH,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 64'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_BYTES = 64'h0800_0000
) (
  input  logic              clk,
  input  logic              reset,
  axi_rd_responder_if.slave bus,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic [1:0]        size;
  resp_t             chk_resp;
  logic [ADDR_W-1:0] word_addr;

  // addr is stable from RD through RESP, so the check result is valid in all three.
  axi_rd_addr_chk #(
    .ADDR_W    (ADDR_W),
    .MEM_BASE  (MEM_BASE),
    .MEM_BYTES (MEM_BYTES)
  ) u_chk (
    .addr      (addr),
    .size      (size),
    .resp      (chk_resp),
    .word_addr (word_addr)
  );

  assign bus.ar_ready = (state == ST_IDLE) && !reset;
  assign mem_en       = (state == ST_RD) && (chk_resp == RESP_OKAY);
  assign mem_addr     = word_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      size        <= SIZE_B;
      bus.r_valid <= 1'b0;
      bus.r_data  <= '0;
      bus.r_resp  <= RESP_OKAY;
      bus.r_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ar_valid) begin
            addr  <= bus.ar_addr;
            len   <= bus.ar_len;
            size  <= bus.ar_size;
            cnt   <= '0;
            state <= ST_RD;
          end
        end
        // Read strobe issued combinationally here; memory answers next cycle.
        ST_RD: begin
          state <= ST_WAIT;
        end
        // Capture memory word and beat status into the R registers.
        ST_WAIT: begin
          bus.r_data  <= (chk_resp == RESP_OKAY) ? mem_rdata : '0;
          bus.r_resp  <= chk_resp;
          bus.r_last  <= (cnt == len);
          bus.r_valid <= 1'b1;
          state       <= ST_RESP;
        end
        // Hold R outputs until the master takes the beat.
        ST_RESP: begin
          if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
            if (bus.r_last) begin
              state <= ST_IDLE;
            end else begin
              addr  <= addr + (ADDR_W'(1) << size);
              cnt   <= cnt + 1'b1;
              state <= ST_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
module tb_axi_rd_responder;

  localparam logic [63:0] MEM_BASE  = 64'h8000_0000;
  localparam logic [63:0] MEM_BYTES = 64'h0800_0000;

  logic        clk;
  logic        reset;
  logic        mem_en;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;

  int n_vec;
  int n_err;
  int mem_en_seen;
  int mem_en_exp;

  axi_rd_responder_if bus ();

  axi_rd_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents as a pure function of the word address.
  function automatic logic [63:0] word_fn(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] * 32'h9E37_79B1};
  endfunction

  // Synchronous memory: random junk unless strobed, so stale data cannot pass.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata   <= word_fn(mem_addr);
      mem_en_seen <= mem_en_seen + 1;
    end else begin
      mem_rdata <= {$urandom, $urandom};
    end
  end

  function automatic logic [1:0] ref_resp(input logic [63:0] a, input logic [1:0] sz);
    if (a < MEM_BASE || a >= MEM_BASE + MEM_BYTES) return 2'b11;
    if ((a % (64'd1 << sz)) != 64'd0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One AR plus all its R beats on a fixed cycle schedule.
  // stall0: r_ready-low cycles on beat 0; rnd: random stalls on later beats;
  // abort_at: beat index whose RESP phase is cut by an async reset (-1 = none).
  task automatic burst(input logic [63:0] a, input logic [7:0] len, input logic [1:0] sz,
                       input int stall0, input bit rnd, input int abort_at);
    logic [63:0] ai;
    logic [1:0]  er;
    logic [63:0] ed;
    int          st;
    @(negedge clk);
    chk("ar_ready_idle", bus.ar_ready, 1'b1);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = a;
    bus.ar_len   = len;
    bus.ar_size  = sz;
    @(posedge clk);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    bus.ar_addr  = {$urandom, $urandom};
    bus.ar_len   = 8'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      ai = a + 64'(i) * (64'd1 << sz);
      er = ref_resp(ai, sz);
      ed = (er == 2'b00) ? word_fn(ai & ~64'd7) : 64'd0;
      st = (i == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
      // RD
      chk("ar_ready_busy", bus.ar_ready, 1'b0);
      chk("rd_r_valid", bus.r_valid, 1'b0);
      chk("rd_mem_en", mem_en, (er == 2'b00));
      if (er == 2'b00) begin
        chk("mem_addr", mem_addr, ai & ~64'd7);
        mem_en_exp++;
      end
      bus.r_ready = (st == 0);
      @(negedge clk);
      // WAIT
      chk("wait_r_valid", bus.r_valid, 1'b0);
      chk("wait_mem_en", mem_en, 1'b0);
      @(negedge clk);
      // RESP
      chk("r_valid", bus.r_valid, 1'b1);
      chk("r_data", bus.r_data, ed);
      chk("r_resp", bus.r_resp, er);
      chk("r_last", bus.r_last, (i == int'(len)));
      if (i == abort_at) begin
        bus.r_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_r_valid", bus.r_valid, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_ar_ready", bus.ar_ready, 1'b0);
        chk("rst_r_data", bus.r_data, 64'd0);
        chk("rst_r_last", bus.r_last, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ar_ready", bus.ar_ready, 1'b1);
        chk("post_rst_r_valid", bus.r_valid, 1'b0);
        bus.r_ready = 1'b1;
        return;
      end
      for (int k = 0; k < st; k++) begin
        @(negedge clk);
        chk("stall_r_valid", bus.r_valid, 1'b1);
        chk("stall_r_data", bus.r_data, ed);
        chk("stall_r_resp", bus.r_resp, er);
        chk("stall_r_last", bus.r_last, (i == int'(len)));
        chk("stall_mem_en", mem_en, 1'b0);
      end
      bus.r_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    chk("done_r_valid", bus.r_valid, 1'b0);
    chk("done_ar_ready", bus.ar_ready, 1'b1);
  endtask

  initial begin
    logic [63:0] ra;
    logic [1:0]  rs;
    int          sel;
    n_vec        = 0;
    n_err        = 0;
    mem_en_seen  = 0;
    mem_en_exp   = 0;
    mem_rdata    = 64'd0;
    reset        = 1'b1;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = 64'd0;
    bus.ar_len   = 8'd0;
    bus.ar_size  = 2'd0;
    bus.r_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_ar_ready", bus.ar_ready, 1'b0);
    chk("reset_r_valid", bus.r_valid, 1'b0);
    chk("reset_r_last", bus.r_last, 1'b0);
    chk("reset_r_resp", bus.r_resp, 2'b00);
    chk("reset_r_data", bus.r_data, 64'd0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    reset = 1'b0;

    // Directed cases
    burst(64'h8000_0000, 8'd0, 2'd3, 0, 1'b0, -1);
    burst(64'h8000_0010, 8'd3, 2'd3, 0, 1'b0, -1);
    burst(64'h8000_0040, 8'd1, 2'd3, 5, 1'b0, -1);
    burst(64'h0000_1000, 8'd0, 2'd3, 0, 1'b0, -1);
    burst(64'h8000_0004, 8'd0, 2'd3, 0, 1'b0, -1);
    burst(64'h8000_0004, 8'd0, 2'd2, 0, 1'b0, -1);
    burst(64'h87FF_FFF8, 8'd1, 2'd3, 0, 1'b0, -1);
    burst(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 2'd3, 0, 1'b0, -1);
    burst(64'h8000_0003, 8'd2, 2'd0, 1, 1'b1, -1);
    burst(64'h8000_0006, 8'd3, 2'd1, 0, 1'b1, -1);
    burst(64'h8000_0100, 8'd3, 2'd3, 0, 1'b0, 1);
    burst(64'h8000_0200, 8'd1, 2'd3, 0, 1'b0, -1);
    burst(64'h8000_1000, 8'd255, 2'd3, 0, 1'b0, -1);

    // Randomized bursts
    for (int b = 0; b < 30; b++) begin
      sel = int'($urandom_range(0, 9));
      rs  = 2'($urandom_range(0, 3));
      if (sel <= 6) ra = MEM_BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
      else if (sel == 7) ra = 64'h87FF_FFE0 + 64'($urandom_range(0, 31));
      else if (sel == 8) ra = 64'($urandom);
      else ra = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
      if (sel < 5) ra = ra & ~((64'd1 << rs) - 64'd1);
      burst(ra, 8'($urandom_range(0, 5)), rs, int'($urandom_range(0, 3)), 1'b1, -1);
    end

    @(negedge clk);
    chk("mem_en_total", 64'(mem_en_seen), 64'(mem_en_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel responder (slave) backed by a simple single-port synchronous memory.
- It accepts AR requests from the fetch/PC stage, walks INCR bursts and returns R beats with handshake and backpressure.
- It sits between the CPU AR/R master ports and the instruction/data SRAM model.

Parameters:
- ADDR_W, 64, address width (`ysyx_22041071_ADDR_BUS`).
- DATA_W, 64, R data width.
- LEN_W, 8, burst length field width (`ysyx_22041071_AXI_LEN_WIDTH`).
- MEM_BASE, 64'h8000_0000, first decoded byte address.
- MEM_BYTES, 64'h0800_0000, decoded window size in bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  responder can accept AR.
- ar_addr  in  ADDR_W  burst start byte address.
- ar_len  in  LEN_W  beats minus 1.
- ar_size  in  2  log2 bytes per beat (0=B, 1=H, 2=W, 3=D).
- r_valid  out  1  read data valid.
- r_ready  in  1  master accepts beat.
- r_data  out  DATA_W  full 64-bit aligned memory word.
- r_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- r_last  out  1  final beat of burst.
- mem_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  8-byte-aligned word address ({addr[63:3],3'b0}).
- mem_rdata  in  DATA_W  valid exactly one cycle after mem_en.

Behaviour:
- Reset: clk is the single clock; reset is asynchronous and active-high.
  - While reset is asserted: state=IDLE, ar_ready=0 (gated by reset), r_valid=0, r_last=0, r_resp=00, r_data=0, mem_en=0, mem_addr=0, internal addr/count=0.
  - Reset mid-burst aborts the burst immediately; the remaining beats are never sent.
- FSM states: IDLE, RD, WAIT, RESP.
- IDLE:
  - ar_ready=1.
  - On ar_valid&ar_ready, latch addr, len, size; set beat count=0; go to RD.
- RD:
  - Check the current addr.
  - If addr is outside [MEM_BASE, MEM_BASE+MEM_BYTES): err=DECERR.
  - Else if addr[2:0] has any bit set below bit `size` (misaligned): err=SLVERR.
  - Else err=OKAY.
  - mem_en=1 only when err==OKAY, with mem_addr = aligned addr.
  - Go to WAIT.
- WAIT:
  - Register r_data = (err==OKAY) ? mem_rdata : 0.
  - Register r_resp=err and r_last=(count==len).
  - Go to RESP.
- RESP:
  - r_valid=1; r_data, r_resp and r_last are held stable until r_ready.
  - On r_valid&r_ready:
    - If r_last, go to IDLE (r_valid drops the next cycle).
    - Else addr += (1<<size) mod 2^ADDR_W, count += 1, go to RD.
- Latency:
  - AR handshake at cycle T gives mem_en at T+1 and first r_valid at T+3.
  - Each subsequent beat arrives 3 cycles after the previous R handshake (no overlap).
- Request handling:
  - Exactly one outstanding burst; ar_ready=0 outside IDLE.
  - An AR presented during a burst waits; it is not dropped.
- Error beats:
  - Every beat gets its own error check; a burst can mix OKAY and error beats.
  - Error beats still take the full RD/WAIT timing and produce no mem_en.
- Address arithmetic:
  - 4 KB boundary crossing is not checked.
  - Wrap past 2^64-1 goes to 0, which then decodes as DECERR.
- Burst length: ar_len=0 gives a single beat with r_last=1; ar_len=255 gives 256 beats.
- Backpressure: r_ready low for N cycles stalls in RESP with all R outputs constant and mem_en=0.

Decomposition:
- Shared define.v holds:
  - `ysyx_22041071_ADDR_BUS`, `ysyx_22041071_AXI_LEN_WIDTH`.
  - SIZE_B/H/W/D codes.
  - RESP_OKAY/SLVERR/DECERR codes.
  - FSM state encodings (2 bits).
- One natural sub-module: axi_rd_addr_chk (combinational: addr, size → resp code, aligned word address).
- FSM, counter and R registers stay in the top module.

Test Plan:
- Single beat: AR addr=0x8000_0000, len=0, size=3, mem word 0x1122334455667788, r_ready=1 → ar_ready low from T+1, mem_en at T+1 addr 0x8000_0000, r_valid at T+3 with data 0x1122334455667788, resp 00, last 1, then IDLE.
- INCR burst: addr=0x8000_0010, len=3, size=3 → 4 beats from mem_addr 0x..10, 0x..18, 0x..20, 0x..28; r_last only on the 4th beat.
- Backpressure: burst len=1, r_ready low for 5 cycles on beat 0 → r_valid/r_data/r_last stable for 6 cycles, no mem_en; beat 1 follows 3 cycles after the handshake.
- Errors:
  - addr=0x0000_1000 → resp 11, data 0, no mem_en.
  - addr=0x8000_0004, size=3 → resp 10.
  - addr=0x8000_0004, size=2 → resp 00.
- Boundary: addr=0x87FF_FFF8, len=1, size=3 → beat 0 OKAY, beat 1 (0x8800_0000) DECERR with r_last=1.
- Reset mid-burst: assert reset during RESP of beat 1 of len=3 (async, between edges) → r_valid and mem_en drop immediately; after release ar_ready=1 and a new AR is served normally.
